// File: rtl/dram_readout_uart_dumper_if.sv
// Byte handshake between the readout frame engine and a uart_send instance.
interface dram_readout_uart_dumper_if;
  logic       uart_en;
  logic [7:0] uart_din;
  logic       uart_busy;

  modport master (output uart_en, output uart_din, input uart_busy);
  modport slave  (input uart_en, input uart_din, output uart_busy);
endinterface

// File: rtl/dram_readout_uart_dumper.sv
// Snapshots NCH readout channels on an rd_done rising edge and streams them as
// one framed byte sequence (raw or hex ASCII) into uart_send.
module dram_readout_uart_dumper #(
  parameter int         NCH     = 16,
  parameter int         DW      = 8,
  parameter logic [7:0] HDR     = 8'h53,
  parameter logic [7:0] SEP     = 8'h0A,
  parameter int         BUSY_TO = 8
) (
  input  logic                       clk_100m,
  input  logic                       rst,
  input  logic                       rd_done,
  input  logic [NCH*DW-1:0]          data_flat,
  input  logic                       hex_mode,
  dram_readout_uart_dumper_if.master uart,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 drop_cnt
);
  localparam int RAW_LEN = 1 + NCH*(DW/8+1);
  localparam int HEX_LEN = 1 + NCH*(DW/4+1);
  localparam int BW      = $clog2(HEX_LEN);
  localparam int CIW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW      = $clog2(DW/4+1);
  localparam int TW      = $clog2(BUSY_TO+1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT, DONE} state_t;
  state_t state_reg, state_next;

  logic              rd_done_q;
  logic              trig;
  logic [NCH*DW-1:0] snap_data_reg;
  logic              snap_hex_reg;
  logic              hdr_sent_reg;
  logic [BW-1:0]     byte_idx_reg;
  logic [CIW-1:0]    ch_idx_reg;
  logic [SW-1:0]     sub_idx_reg;
  logic [TW-1:0]     to_cnt_reg;
  logic [7:0]        din_reg;
  logic [7:0]        drop_cnt_reg;
  logic [DW-1:0]     chan [NCH];
  logic [DW-1:0]     cur_word;
  logic [SW-1:0]     pay_len;
  logic [7:0]        pay_byte;
  logic              last_byte;
  int                raw_pos;
  int                hex_pos;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign chan[gi] = snap_data_reg[gi*DW +: DW];
    end
  endgenerate

  assign trig = rd_done & ~rd_done_q;

  // Part-select bases are clamped so the unused mode never indexes out of range.
  always_comb begin
    cur_word = chan[ch_idx_reg];
    pay_len  = snap_hex_reg ? SW'(DW/4) : SW'(DW/8);
    raw_pos  = 0;
    hex_pos  = 0;
    if (sub_idx_reg < SW'(DW/8)) raw_pos = DW - 8 - 8*int'(sub_idx_reg);
    if (sub_idx_reg < SW'(DW/4)) hex_pos = DW - 4 - 4*int'(sub_idx_reg);
    pay_byte  = snap_hex_reg ? hex_char(cur_word[hex_pos +: 4]) : cur_word[raw_pos +: 8];
    last_byte = hdr_sent_reg &&
                (byte_idx_reg == (snap_hex_reg ? BW'(HEX_LEN-1) : BW'(RAW_LEN-1)));
  end

  always_ff @(posedge clk_100m) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trig) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    state_next = WAIT_HI;
      WAIT_HI: if (uart.uart_busy)                    state_next = WAIT_LO;
               else if (to_cnt_reg == TW'(BUSY_TO-1)) state_next = NEXT;
      WAIT_LO: if (!uart.uart_busy) state_next = NEXT;
      NEXT:    state_next = last_byte ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rd_done_q resets high so a level already present at reset release is not an edge.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      rd_done_q     <= 1'b1;
      snap_data_reg <= '0;
      snap_hex_reg  <= 1'b0;
      hdr_sent_reg  <= 1'b0;
      byte_idx_reg  <= '0;
      ch_idx_reg    <= '0;
      sub_idx_reg   <= '0;
      to_cnt_reg    <= '0;
      din_reg       <= 8'h00;
      drop_cnt_reg  <= 8'h00;
    end else begin
      rd_done_q <= rd_done;
      if (trig && state_reg != IDLE && drop_cnt_reg != 8'hFF)
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      case (state_reg)
        IDLE: if (trig) begin
          snap_data_reg <= data_flat;
          snap_hex_reg  <= hex_mode;
          hdr_sent_reg  <= 1'b0;
          byte_idx_reg  <= '0;
          ch_idx_reg    <= '0;
          sub_idx_reg   <= '0;
        end
        LOAD: if (!hdr_sent_reg) begin
          din_reg      <= HDR;
          hdr_sent_reg <= 1'b1;
        end else begin
          byte_idx_reg <= byte_idx_reg + BW'(1);
          if (sub_idx_reg == pay_len) begin
            din_reg     <= SEP;
            sub_idx_reg <= '0;
            ch_idx_reg  <= ch_idx_reg + CIW'(1);
          end else begin
            din_reg     <= pay_byte;
            sub_idx_reg <= sub_idx_reg + SW'(1);
          end
        end
        SEND:    to_cnt_reg <= '0;
        WAIT_HI: to_cnt_reg <= to_cnt_reg + TW'(1);
        default: ;
      endcase
    end
  end

  assign uart.uart_en  = (state_reg == SEND);
  assign uart.uart_din = din_reg;
  assign busy          = (state_reg != IDLE);
  assign frame_done    = (state_reg == DONE);
  assign drop_cnt      = drop_cnt_reg;
endmodule
